asi_ram_arb: RTL and testbench

- Shares one single-port synchronous user RAM between the AXI slave interface's user-side write requester and read requester.
- Per-beat grant handshake to each requester; a grant is held across a burst up to a fairness limit, with round-robin between bursts.
- Drives the RAM port and returns read data after a fixed RAM wait-state latency, tagged with a valid strobe.
- Sits between the slave interface's user ports and the RAM, in the user clock domain.

---
 rtl/asi_pkg.sv | 18 +
 rtl/asi_ram_arb_if.sv | 38 +++
 rtl/asi_arb_dly.sv | 32 +++
 rtl/asi_ram_arb.sv | 115 +++++++++++
 tb/tb_asi_ram_arb.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asi_pkg.sv
// Shared AXI slave-interface widths plus the user RAM arbiter's owner type.
package asi_pkg;

  localparam int unsigned AXI_AW     = 32;
  localparam int unsigned AXI_DW     = 32;
  localparam int unsigned AXI_WSTRBW = AXI_DW / 8;
  localparam int unsigned ARB_HOLD_W = 8;

  typedef enum logic {
    OWN_W = 1'b0,
    OWN_R = 1'b1
  } owner_e;

  function automatic owner_e other_side(owner_e o);
    return (o == OWN_W) ? OWN_R : OWN_W;
  endfunction

endpackage

// File: rtl/asi_ram_arb_if.sv
// User-side write/read beat ports and single-port RAM port of the RAM arbiter.
interface asi_ram_arb_if;
  import asi_pkg::*;

  logic                  w_req;
  logic [AXI_AW-1:0]     w_addr;
  logic [AXI_DW-1:0]     w_data;
  logic [AXI_WSTRBW-1:0] w_strb;
  logic                  w_last;
  logic                  w_gnt;

  logic                  r_req;
  logic [AXI_AW-1:0]     r_addr;
  logic                  r_last;
  logic                  r_gnt;
  logic [AXI_DW-1:0]     r_data;
  logic                  r_dvalid;

  logic                  ram_ce;
  logic                  ram_we;
  logic [AXI_AW-1:0]     ram_addr;
  logic [AXI_DW-1:0]     ram_wdata;
  logic [AXI_WSTRBW-1:0] ram_be;
  logic [AXI_DW-1:0]     ram_rdata;

  // Arbiter view.
  modport slave (
    input  w_req, w_addr, w_data, w_strb, w_last, r_req, r_addr, r_last, ram_rdata,
    output w_gnt, r_gnt, r_data, r_dvalid, ram_ce, ram_we, ram_addr, ram_wdata, ram_be
  );

  // Requester / RAM view.
  modport master (
    output w_req, w_addr, w_data, w_strb, w_last, r_req, r_addr, r_last, ram_rdata,
    input  w_gnt, r_gnt, r_data, r_dvalid, ram_ce, ram_we, ram_addr, ram_wdata, ram_be
  );

endinterface

// File: rtl/asi_arb_dly.sv
// Read-valid delay line matching the RAM read wait states; Depth=0 is a pass-through.
module asi_arb_dly #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  if (Depth == 0) begin : g_pass
    assign valid_o = valid_i;
  end else begin : g_dly
    logic [Depth-1:0] dly_q, dly_d;

    always_comb begin
      dly_d    = dly_q << 1;
      dly_d[0] = valid_i;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dly_q <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end

    assign valid_o = dly_q[Depth-1];
  end

endmodule

// File: rtl/asi_ram_arb.sv
// Arbitrates one single-port user RAM between a write and a read beat requester,
// holding a burst up to MAX_HOLD beats against a waiting peer, round-robin between bursts.
module asi_ram_arb
  import asi_pkg::*;
#(
  parameter int unsigned SLV_WS   = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         usr_clk,
  input  logic         usr_reset,
  asi_ram_arb_if.slave bus_io
);

  // One extra bit so a hold limit of 256 is representable.
  localparam int unsigned   HoldW   = ARB_HOLD_W + 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic             owner_lock_q, owner_lock_d;
  owner_e           lock_owner_q, lock_owner_d;
  owner_e           rr_next_q, rr_next_d;
  logic [HoldW-1:0] hold_q, hold_d;

  owner_e owner;
  logic   owner_vld;
  logic   other_req;
  logic   fair_cut;
  logic   w_gnt, r_gnt, any_gnt, beat_last;
  logic   r_dvalid_raw;

  always_comb begin
    owner     = rr_next_q;
    owner_vld = 1'b0;
    if (owner_lock_q) begin
      owner     = lock_owner_q;
      owner_vld = 1'b1;
    end else if (bus_io.w_req && bus_io.r_req) begin
      owner     = rr_next_q;
      owner_vld = 1'b1;
    end else if (bus_io.w_req) begin
      owner     = OWN_W;
      owner_vld = 1'b1;
    end else if (bus_io.r_req) begin
      owner     = OWN_R;
      owner_vld = 1'b1;
    end
  end

  assign other_req = (owner == OWN_W) ? bus_io.r_req : bus_io.w_req;
  // Limit reached with the peer waiting: spend one idle cycle to break the lock.
  assign fair_cut  = owner_lock_q && (hold_q == HoldMax) && other_req;

  assign w_gnt     = !usr_reset && owner_vld && !fair_cut && (owner == OWN_W) && bus_io.w_req;
  assign r_gnt     = !usr_reset && owner_vld && !fair_cut && (owner == OWN_R) && bus_io.r_req;
  assign any_gnt   = w_gnt || r_gnt;
  assign beat_last = w_gnt ? bus_io.w_last : bus_io.r_last;

  always_comb begin
    owner_lock_d = owner_lock_q;
    lock_owner_d = lock_owner_q;
    rr_next_d    = rr_next_q;
    hold_d       = hold_q;
    if (fair_cut) begin
      owner_lock_d = 1'b0;
      hold_d       = '0;
      rr_next_d    = other_side(lock_owner_q);
    end else if (any_gnt) begin
      if (beat_last) begin
        owner_lock_d = 1'b0;
        hold_d       = '0;
        rr_next_d    = other_side(owner);
      end else begin
        owner_lock_d = 1'b1;
        lock_owner_d = owner;
        if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
    end
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      owner_lock_q <= 1'b0;
      lock_owner_q <= OWN_W;
      rr_next_q    <= OWN_W;
      hold_q       <= '0;
    end else begin
      owner_lock_q <= owner_lock_d;
      lock_owner_q <= lock_owner_d;
      rr_next_q    <= rr_next_d;
      hold_q       <= hold_d;
    end
  end

  assign bus_io.w_gnt     = w_gnt;
  assign bus_io.r_gnt     = r_gnt;
  assign bus_io.ram_ce    = any_gnt;
  assign bus_io.ram_we    = w_gnt;
  assign bus_io.ram_addr  = r_gnt ? bus_io.r_addr : bus_io.w_addr;
  assign bus_io.ram_wdata = bus_io.w_data;
  assign bus_io.ram_be    = r_gnt ? '1 : bus_io.w_strb;

  asi_arb_dly #(
    .Depth(SLV_WS)
  ) u_dly (
    .clk_i  (usr_clk),
    .rst_i  (usr_reset),
    .valid_i(r_gnt),
    .valid_o(r_dvalid_raw)
  );

  assign bus_io.r_dvalid = r_dvalid_raw && !usr_reset;
  assign bus_io.r_data   = bus_io.ram_rdata;

endmodule

// File: tb/tb_asi_ram_arb.sv
// Scoreboard bench for asi_ram_arb: directed arbitration scenarios plus randomized traffic.
module tb_asi_ram_arb;
  import asi_pkg::*;

  localparam int unsigned SLV_WS   = 2;
  localparam int unsigned MAX_HOLD = 4;

  typedef struct {
    logic [AXI_AW-1:0]     addr;
    logic [AXI_DW-1:0]     data;
    logic [AXI_WSTRBW-1:0] strb;
    logic                  last;
  } wbeat_t;

  typedef struct {
    logic [AXI_AW-1:0] addr;
    logic              last;
  } rbeat_t;

  typedef struct {
    logic [AXI_DW-1:0] data;
    int                cyc;
  } exp_t;

  logic usr_clk = 1'b0;
  logic usr_reset;
  always #5 usr_clk = ~usr_clk;

  asi_ram_arb_if bus ();

  asi_ram_arb #(
    .SLV_WS  (SLV_WS),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .usr_clk  (usr_clk),
    .usr_reset(usr_reset),
    .bus_io   (bus)
  );

  wbeat_t wq[$];
  rbeat_t rq[$];
  exp_t   eq[$];
  exp_t   mon_e;

  logic [31:0] shadow[64];
  logic [31:0] mem[64];
  logic [31:0] pipe[SLV_WS];
  logic        mem_init = 1'b1;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rd_cnt = 0;
  int    dv_cnt = 0;
  int    dropped = 0;
  int    w_pause = 0;
  int    r_pause = 0;
  logic  rst_ctl;
  logic  logging = 1'b0;
  string glog;
  logic [31:0] last_rdata;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with SLV_WS read wait states.
  always @(posedge usr_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bus.ram_ce && bus.ram_we) begin
      mem[bus.ram_addr[7:2]] <= merge(mem[bus.ram_addr[7:2]], bus.ram_wdata, bus.ram_be);
    end
    pipe[0] <= mem[bus.ram_addr[7:2]];
    for (int i = 1; i < SLV_WS; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[SLV_WS-1];

  always @(posedge usr_clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Read-return monitor: runs after the driver's sample point each cycle.
  always @(negedge usr_clk) begin
    #2;
    if (bus.r_dvalid) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dvalid_unexp: r_dvalid got 1 required 0 (cycle %0d)", cyc);
      end else begin
        mon_e = eq.pop_front();
        chk("r_data", 128'(bus.r_data), 128'(mon_e.data));
        chk("r_latency", 128'(cyc - mon_e.cyc), 128'(SLV_WS));
        last_rdata = bus.r_data;
        dv_cnt++;
      end
    end
  end

  task automatic cycle();
    string c;
    @(negedge usr_clk);
    usr_reset  = rst_ctl;
    bus.w_req  = (wq.size() > 0) && (w_pause == 0);
    bus.r_req  = (rq.size() > 0) && (r_pause == 0);
    if (wq.size() > 0) begin
      bus.w_addr = wq[0].addr;
      bus.w_data = wq[0].data;
      bus.w_strb = wq[0].strb;
      bus.w_last = wq[0].last;
    end
    if (rq.size() > 0) begin
      bus.r_addr = rq[0].addr;
      bus.r_last = rq[0].last;
    end
    #1;
    if (usr_reset) begin
      chk("reset_outputs", 128'({bus.w_gnt, bus.r_gnt, bus.ram_ce, bus.ram_we, bus.r_dvalid}),
          128'(0));
      dropped += eq.size();
      eq.delete();
    end
    if (logging && (wq.size() > 0 || rq.size() > 0)) begin
      c = bus.w_gnt ? "W" : (bus.r_gnt ? "R" : ".");
      glog = $sformatf("%s%s", glog, c);
    end
    if (bus.w_gnt && bus.r_gnt) chk("gnt_exclusive", 128'(1), 128'(0));
    if (bus.ram_ce != (bus.w_gnt || bus.r_gnt) || bus.ram_we != bus.w_gnt)
      chk("ram_ctrl", 128'({bus.ram_ce, bus.ram_we}), 128'({bus.w_gnt || bus.r_gnt, bus.w_gnt}));
    if (bus.w_gnt && !bus.w_req) chk("w_gnt_without_req", 128'(1), 128'(0));
    else if (bus.w_gnt) begin
      chk("w_ram_port", {60'(0), bus.ram_addr, bus.ram_wdata, bus.ram_be},
          {60'(0), wq[0].addr, wq[0].data, wq[0].strb});
      shadow[wq[0].addr[7:2]] = merge(shadow[wq[0].addr[7:2]], wq[0].data, wq[0].strb);
      void'(wq.pop_front());
    end
    if (bus.r_gnt && !bus.r_req) chk("r_gnt_without_req", 128'(1), 128'(0));
    else if (bus.r_gnt) begin
      chk("r_ram_port", 128'({bus.ram_addr, bus.ram_be}), 128'({rq[0].addr, 4'hF}));
      eq.push_back('{data: shadow[rq[0].addr[7:2]], cyc: cyc});
      void'(rq.pop_front());
      rd_cnt++;
    end
    if (w_pause > 0) w_pause--;
    if (r_pause > 0) r_pause--;
  endtask

  task automatic wburst(logic [31:0] base, int n, logic rnd_strb);
    for (int i = 0; i < n; i++)
      wq.push_back('{addr: (base + 32'(4 * i)) & 32'hFC, data: $urandom,
                     strb: rnd_strb ? 4'($urandom_range(1, 15)) : 4'hF, last: (i == n - 1)});
  endtask

  task automatic rburst(logic [31:0] base, int n);
    for (int i = 0; i < n; i++)
      rq.push_back('{addr: (base + 32'(4 * i)) & 32'hFC, last: (i == n - 1)});
  endtask

  task automatic run_idle(string name, int budget);
    int n = 0;
    while ((wq.size() > 0 || rq.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    if (wq.size() > 0 || rq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d beats left required 0", name, wq.size() + rq.size());
      wq.delete();
      rq.delete();
    end
  endtask

  task automatic drain();
    repeat (SLV_WS + 2) cycle();
  endtask

  task automatic start_log();
    glog    = "";
    logging = 1'b1;
  endtask

  task automatic check_log(string name, string exp);
    logging = 1'b0;
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL %s: grants got '%s' required '%s'", name, glog, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ctl    = 1'b1;
    usr_reset  = 1'b1;
    bus.w_req  = 1'b0;
    bus.r_req  = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.w_strb = '0;
    bus.w_last = 1'b0;
    bus.r_addr = '0;
    bus.r_last = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    cycle();
    mem_init = 1'b0;
    repeat (2) cycle();
    rst_ctl = 1'b0;
    drain();

    // Write-only burst, then the round-robin pointer must favour R.
    wburst(32'h0, 4, 1'b0);
    start_log();
    run_idle("w_only", 50);
    check_log("w_only_burst", "WWWW");
    drain();
    wburst(32'h80, 1, 1'b0);
    rburst(32'h80, 1);
    start_log();
    run_idle("rr_after_w", 50);
    check_log("rr_after_w", "RW");
    drain();

    // Both sides requesting out of reset: W first, no bubble between bursts.
    rst_ctl = 1'b1;
    wburst(32'h10, 2, 1'b0);
    rburst(32'h00, 2);
    repeat (2) cycle();
    rst_ctl = 1'b0;
    start_log();
    run_idle("reset_release", 50);
    check_log("reset_release_order", "WWRR");
    drain();

    // Fairness cut after MAX_HOLD beats while the reader waits.
    wburst(32'h20, 10, 1'b0);
    start_log();
    cycle();
    rburst(32'hC0, 3);
    run_idle("fairness", 100);
    check_log("fairness_cut", "WWWW.RRRWWWWWW");
    drain();

    // Read-after-write through the shared RAM, full then partial strobes.
    wq.push_back('{addr: 32'h40, data: 32'hDEADBEEF, strb: 4'hF, last: 1'b1});
    run_idle("raw_w1", 20);
    rburst(32'h40, 1);
    run_idle("raw_r1", 20);
    drain();
    chk("raw_full_word", 128'(last_rdata), 128'(32'hDEADBEEF));
    wq.push_back('{addr: 32'h40, data: 32'h00001111, strb: 4'h3, last: 1'b1});
    run_idle("raw_w2", 20);
    rburst(32'h40, 1);
    run_idle("raw_r2", 20);
    drain();
    chk("raw_partial_word", 128'(last_rdata), 128'(32'hDEAD1111));

    // Locked reader pauses: writer must wait and the hold count must not advance.
    rburst(32'hA0, 4);
    start_log();
    cycle();
    r_pause = 3;
    wburst(32'h60, 1, 1'b0);
    run_idle("lock_pause", 50);
    check_log("locked_owner_pause", "R...RRRW");
    drain();

    // Reset mid read burst: in-flight returns dropped, W wins after release.
    rburst(32'hB0, 4);
    repeat (2) cycle();
    rst_ctl = 1'b1;
    wburst(32'h70, 1, 1'b0);
    repeat (2) cycle();
    rst_ctl = 1'b0;
    start_log();
    run_idle("reset_mid", 50);
    check_log("reset_mid_burst", "WRR");
    drain();

    // Randomized traffic with random requester pauses.
    for (int b = 0; b < 30; b++) begin
      wburst({24'(0), 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(1, 6), 1'b1);
      rburst({24'(0), 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(1, 6));
    end
    begin
      int n = 0;
      while ((wq.size() > 0 || rq.size() > 0) && n < 4000) begin
        if (w_pause == 0 && $urandom_range(0, 7) == 0) w_pause = $urandom_range(1, 3);
        if (r_pause == 0 && $urandom_range(0, 7) == 0) r_pause = $urandom_range(1, 3);
        cycle();
        n++;
      end
    end
    run_idle("random", 100);
    drain();
    chk("read_beat_balance", 128'(dv_cnt + dropped), 128'(rd_cnt));
    chk("scoreboard_empty", 128'(eq.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
